// File: rtl/pipelined_controller.sv
// RV32I main decoder plus the ID/EX, EX/MEM and MEM/WB control registers.
// Generates the load-use stall and the branch flush, and honours a whole-pipe freeze.
module pipelined_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter bit U_TYPE_EN    = 1'b1,
  parameter bit LOAD_USE_DET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  branch_taken_i,
  input  logic                  ext_stall_i,
  output logic                  hazard_stall_o,
  output logic                  flush_o,
  output logic                  ex_ALU_src,
  output logic                  ex_ALU_a_pc,
  output logic [1:0]            ex_ALU_op,
  output logic [1:0]            ex_ctrl_transfer,
  output logic                  ex_illegal,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_data_src,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic                  alu_src;
    logic                  alu_a_pc;
    logic [1:0]            alu_op;
    logic [1:0]            ct;
    logic                  illegal;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [1:0]            wb_src;
    logic [REG_ADDR_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [1:0]            wb_src;
    logic [REG_ADDR_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            wb_src;
    logic [REG_ADDR_W-1:0] rd;
  } memwb_t;

  idex_t  dec, idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic   rs1_used, rs2_used, load_use;

  // ID-stage decode of the opcode into a control bundle plus source-register usage
  always_comb begin
    dec      = '0;
    dec.rd   = rd;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OPC_OP:     begin dec.reg_write = 1'b1; dec.alu_op = 2'b01; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_OP_IMM: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b11; rs1_used = 1'b1; end
      OPC_LOAD:   begin dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.wb_src = 2'b01;
                        rs1_used = 1'b1; end
      OPC_STORE:  begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_BRANCH: begin dec.alu_op = 2'b10; dec.ct = 2'b01; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_JAL:    begin dec.reg_write = 1'b1; dec.wb_src = 2'b10; dec.ct = 2'b10; end
      OPC_JALR:   begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.wb_src = 2'b10; dec.ct = 2'b11;
                        rs1_used = 1'b1; end
      OPC_AUIPC:  if (U_TYPE_EN) begin dec.alu_src = 1'b1; dec.alu_a_pc = 1'b1; dec.reg_write = 1'b1; end
                  else dec.illegal = 1'b1;
      OPC_LUI:    if (U_TYPE_EN) begin dec.reg_write = 1'b1; dec.wb_src = 2'b11; end
                  else dec.illegal = 1'b1;
      default:    dec.illegal = 1'b1;
    endcase
    // x0 is never written
    if (rd == '0) dec.reg_write = 1'b0;
  end

  // Load in EX whose destination feeds a source the ID instruction actually reads
  assign load_use = idex_q.mem_read && (idex_q.rd != '0) &&
                    ((rs1_used && (rs1 == idex_q.rd)) || (rs2_used && (rs2 == idex_q.rd)));

  // Freeze outranks flush, flush outranks the load-use stall
  assign flush_o        = branch_taken_i & ~ext_stall_i & ~reset;
  assign hazard_stall_o = LOAD_USE_DET & load_use & ~branch_taken_i & ~ext_stall_i & ~reset;

  // Next-state for each stage; a bubble is the all-zero bundle
  always_comb begin
    idex_d  = (flush_o || hazard_stall_o) ? '0 : dec;
    exmem_d = '{mem_read: idex_q.mem_read, mem_write: idex_q.mem_write, reg_write: idex_q.reg_write,
                wb_src: idex_q.wb_src, rd: idex_q.rd};
    memwb_d = '{reg_write: exmem_q.reg_write, wb_src: exmem_q.wb_src, rd: exmem_q.rd};
  end

  // Control pipeline registers: cleared by reset, all held during an external freeze
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (!ext_stall_i) begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_ALU_src       = idex_q.alu_src;
  assign ex_ALU_a_pc      = idex_q.alu_a_pc;
  assign ex_ALU_op        = idex_q.alu_op;
  assign ex_ctrl_transfer = idex_q.ct;
  assign ex_illegal       = idex_q.illegal;
  assign mem_read         = exmem_q.mem_read;
  assign mem_write        = exmem_q.mem_write;
  assign wb_reg_write     = memwb_q.reg_write;
  assign wb_data_src      = memwb_q.wb_src;
  assign wb_rd            = memwb_q.rd;

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: directed table, hand sequence, and random traffic
// checked against an instruction-level pipeline model. Two instances are run side by
// side: default parameters (a) and U-type/load-use disabled (b).
module tb_pipelined_controller;

  localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63,
                         JAL = 7'h6F, JALR = 7'h67, AUI = 7'h17, LUI = 7'h37, ILL = 7'h7F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, bt, es;
  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd;

  logic       haz_a, fl_a, src_a, apc_a, ill_a, mr_a, mw_a, rw_a;
  logic [1:0] op_a, ct_a, wbs_a;
  logic [4:0] wrd_a;
  logic       haz_b, fl_b, src_b, apc_b, ill_b, mr_b, mw_b, rw_b;
  logic [1:0] op_b, ct_b, wbs_b;
  logic [4:0] wrd_b;

  pipelined_controller #(.REG_ADDR_W(5), .U_TYPE_EN(1'b1), .LOAD_USE_DET(1'b1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .branch_taken_i(bt), .ext_stall_i(es), .hazard_stall_o(haz_a), .flush_o(fl_a),
    .ex_ALU_src(src_a), .ex_ALU_a_pc(apc_a), .ex_ALU_op(op_a), .ex_ctrl_transfer(ct_a),
    .ex_illegal(ill_a), .mem_read(mr_a), .mem_write(mw_a), .wb_reg_write(rw_a),
    .wb_data_src(wbs_a), .wb_rd(wrd_a));

  pipelined_controller #(.REG_ADDR_W(5), .U_TYPE_EN(1'b0), .LOAD_USE_DET(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .branch_taken_i(bt), .ext_stall_i(es), .hazard_stall_o(haz_b), .flush_o(fl_b),
    .ex_ALU_src(src_b), .ex_ALU_a_pc(apc_b), .ex_ALU_op(op_b), .ex_ctrl_transfer(ct_b),
    .ex_illegal(ill_b), .mem_read(mr_b), .mem_write(mw_b), .wb_reg_write(rw_b),
    .wb_data_src(wbs_b), .wb_rd(wrd_b));

  wire [16:0] regs_a = {src_a, apc_a, op_a, ct_a, ill_a, mr_a, mw_a, rw_a, wbs_a, wrd_a};
  wire [16:0] regs_b = {src_b, apc_b, op_b, ct_b, ill_b, mr_b, mw_b, rw_b, wbs_b, wrd_b};

  int vectors = 0, miscompares = 0;

  // ---------------- reference model: whole instructions moving through EX, MEM, WB
  typedef struct packed {
    logic src, apc; logic [1:0] op, ct; logic ill, mr, mw, rw; logic [1:0] wbs; logic [4:0] rd;
  } ins_t;

  ins_t mp [2][3];   // [config][0=EX,1=MEM,2=WB]

  function automatic ins_t decode(input logic [6:0] o, input logic [4:0] d, input bit uen);
    ins_t c = '0;
    c.rd = d;
    if      (o == OP)   begin c.rw = 1; c.op = 2'b01; end
    else if (o == OPI)  begin c.src = 1; c.rw = 1; c.op = 2'b11; end
    else if (o == LD)   begin c.src = 1; c.mr = 1; c.rw = 1; c.wbs = 2'b01; end
    else if (o == ST)   begin c.src = 1; c.mw = 1; end
    else if (o == BR)   begin c.op = 2'b10; c.ct = 2'b01; end
    else if (o == JAL)  begin c.rw = 1; c.wbs = 2'b10; c.ct = 2'b10; end
    else if (o == JALR) begin c.src = 1; c.rw = 1; c.wbs = 2'b10; c.ct = 2'b11; end
    else if (o == AUI && uen) begin c.src = 1; c.apc = 1; c.rw = 1; end
    else if (o == LUI && uen) begin c.rw = 1; c.wbs = 2'b11; end
    else c.ill = 1;
    c.rw = c.rw & (d != 0);
    return c;
  endfunction

  function automatic bit m_flush();
    return bt && !es && !reset;
  endfunction

  function automatic bit m_haz(input int k);
    bit r1 = (opc inside {OP, OPI, LD, ST, BR, JALR});
    bit r2 = (opc inside {OP, ST, BR});
    ins_t e = mp[k][0];
    if (k == 1 || reset || es || bt || !e.mr || e.rd == 0) return 0;
    return (r1 && rs1 == e.rd) || (r2 && rs2 == e.rd);
  endfunction

  function automatic logic [16:0] m_regs(input int k);
    ins_t e = mp[k][0], m = mp[k][1], w = mp[k][2];
    return {e.src, e.apc, e.op, e.ct, e.ill, m.mr, m.mw, w.rw, w.wbs, w.rd};
  endfunction

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      bit bub = m_flush() || m_haz(k);
      if (reset) begin
        mp[k][0] = '0; mp[k][1] = '0; mp[k][2] = '0;
      end else if (!es) begin
        mp[k][2] = mp[k][1];
        mp[k][1] = mp[k][0];
        mp[k][0] = bub ? '0 : decode(opc, rd, k == 0);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: comb outputs checked just before the edge, registers just after it.
  task automatic run_cycle(output logic ph, output logic pf);
    #3;
    ph = haz_a; pf = fl_a;
    check("comb_a", {30'd0, haz_a, fl_a}, {30'd0, m_haz(0), m_flush()});
    check("comb_b", {30'd0, haz_b, fl_b}, {30'd0, m_haz(1), m_flush()});
    @(posedge clk);
    model_clock();
    #1;
    check("regs_a", {15'd0, regs_a}, {15'd0, m_regs(0)});
    check("regs_b", {15'd0, regs_b}, {15'd0, m_regs(1)});
  endtask

  task automatic drive(input logic r, input logic [6:0] o, input logic [4:0] a, b, d,
                       input logic t, s);
    reset = r; opc = o; rs1 = a; rs2 = b; rd = d; bt = t; es = s;
  endtask

  // ---------------- directed table
  typedef struct {
    logic r; logic [6:0] o; logic [4:0] a, b, d; logic t, s;
    logic haz, fl; logic [1:0] exop, exct; logic ill, ill_b, mr, rw; logic [1:0] wbs;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic ph, pf;
    for (int k = 0; k < 2; k++) for (int j = 0; j < 3; j++) mp[k][j] = '0;
    drive(1, OP, 1, 2, 3, 0, 0);
    //            r  opc  rs1 rs2 rd bt es  haz fl exop exct ill illb mr rw wbs
    tbl.push_back('{1, OP,   1, 2, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, OP,   1, 2, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, OP,   1, 2, 3, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, OPI,  0, 0, 0, 0, 0,  0, 0, 3, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, OPI,  0, 0, 0, 0, 0,  0, 0, 3, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, LD,   1, 0, 5, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, OP,   1, 5, 6, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, OP,   1, 5, 6, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{0, LD,   2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, OP,   0, 3, 7, 0, 0,  0, 0, 1, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{0, OPI,  0, 0, 0, 0, 0,  0, 0, 3, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, LD,   1, 0, 9, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, LD,   9, 0, 4, 1, 0,  0, 1, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, JAL,  0, 0, 1, 0, 0,  0, 0, 0, 2, 0, 0, 0, 1, 1});
    tbl.push_back('{0, BR,   1, 2, 0, 0, 0,  0, 0, 2, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, JALR, 1, 0, 2, 0, 0,  0, 0, 0, 3, 0, 0, 0, 1, 2});
    tbl.push_back('{0, OP,   1, 2, 3, 1, 1,  0, 0, 0, 3, 0, 0, 0, 1, 2});
    tbl.push_back('{0, OP,   1, 2, 3, 1, 1,  0, 0, 0, 3, 0, 0, 0, 1, 2});
    tbl.push_back('{0, OP,   1, 2, 3, 1, 1,  0, 0, 0, 3, 0, 0, 0, 1, 2});
    tbl.push_back('{0, OP,   1, 2, 3, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, LUI,  0, 0, 8, 0, 0,  0, 0, 0, 0, 0, 1, 0, 1, 2});
    tbl.push_back('{0, ILL,  0, 0, 1, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{0, OPI,  0, 0, 0, 0, 0,  0, 0, 3, 0, 0, 0, 0, 1, 3});
    tbl.push_back('{0, OPI,  0, 0, 0, 0, 0,  0, 0, 3, 0, 0, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].t, tbl[i].s);
      run_cycle(ph, pf);
      check($sformatf("row%0d", i),
            {20'd0, ph, pf, op_a, ct_a, ill_a, ill_b, mr_a, rw_a, wbs_a},
            {20'd0, tbl[i].haz, tbl[i].fl, tbl[i].exop, tbl[i].exct, tbl[i].ill,
             tbl[i].ill_b, tbl[i].mr, tbl[i].rw, tbl[i].wbs});
    end

    // Hand sequence: reset arriving mid-flight during a freeze discards everything
    drive(0, LD, 1, 0, 4, 0, 0);  run_cycle(ph, pf);
    drive(0, JAL, 0, 0, 6, 0, 0); run_cycle(ph, pf);
    drive(0, OP, 4, 4, 7, 1, 1);  run_cycle(ph, pf);
    drive(1, OP, 4, 4, 7, 1, 1);  run_cycle(ph, pf);
    check("reset_midflight", {12'd0, ph, pf, regs_a, regs_b[4:0]}, 32'd0);

    // Hand sequence: load-use hazard suppressed while frozen, then raised on release
    drive(0, LD, 1, 0, 5, 0, 0); run_cycle(ph, pf);
    drive(0, ST, 2, 5, 0, 0, 1); run_cycle(ph, pf);
    check("haz_frozen", {31'd0, ph}, 32'd0);
    drive(0, ST, 2, 5, 0, 0, 0); run_cycle(ph, pf);
    check("haz_release", {31'd0, ph}, 32'd1);

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [6:0] pick[10];
      pick = '{OP, OPI, LD, ST, BR, JAL, JALR, AUI, LUI, 7'h00};
      pick[9] = 7'($urandom);
      drive(($urandom_range(0, 40) == 0), pick[$urandom_range(0, 9)],
            5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 6) == 0));
      run_cycle(ph, pf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
